// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 key-event controller.
// Holds the special scan-code byte values, the prefix-decoder state
// enum, the queued event record and small byte classifiers.
package ps2_pkg;

   localparam logic [7:0] BYTE_E0 = 8'hE0;  // extended-key prefix
   localparam logic [7:0] BYTE_F0 = 8'hF0;  // break (release) prefix
   localparam logic [7:0] BYTE_AA = 8'hAA;  // self-test passed
   localparam logic [7:0] BYTE_FA = 8'hFA;  // acknowledge
   localparam logic [7:0] BYTE_FE = 8'hFE;  // resend request
   localparam logic [7:0] BYTE_EE = 8'hEE;  // echo response
   localparam logic [7:0] BYTE_00 = 8'h00;  // key detection error
   localparam logic [7:0] BYTE_FF = 8'hFF;  // key detection error / overrun

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GOT_E0   = 2'd1,
      GOT_F0   = 2'd2,
      GOT_E0F0 = 2'd3
   } dec_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } ps2_evt_t;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == BYTE_E0) || (b == BYTE_F0);
   endfunction

   function automatic logic is_bad(input logic [7:0] b);
      return (b == BYTE_00) || (b == BYTE_FF);
   endfunction

   // Keyboard-to-host control responses; only meaningful outside a prefix.
   function automatic logic is_ctrl(input logic [7:0] b);
      return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE) || (b == BYTE_EE);
   endfunction

endpackage

// File: rtl/ps2_keyctl_if.sv
// ps2_keyctl_if -- byte input and event output handshakes of ps2_keyctl.
//   rx_valid/rx_data : byte strobe from the PS/2 receiver
//   ev_valid/ev_ready: event queue head handshake
//   ev_code/ev_ext/ev_break: head event fields
// slave modport is the controller side, master the receiver/consumer side.
interface ps2_keyctl_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;

   modport master (
      output rx_valid, rx_data, ev_ready,
      input  ev_valid, ev_code, ev_ext, ev_break
   );

   modport slave (
      input  rx_valid, rx_data, ev_ready,
      output ev_valid, ev_code, ev_ext, ev_break
   );
endinterface

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo -- show-ahead event queue.
//   clock, reset (async, active-low)
//   push/push_data : write one record (ignored when full unless popping)
//   pop            : remove the head record (ignored when empty)
//   head           : current head record, zero while empty
//   full/empty     : occupancy status
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module ps2_evt_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     push,
   input  ps2_evt_t push_data,
   input  logic     pop,
   output ps2_evt_t head,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   ps2_evt_t       mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same edge frees the slot the push lands in.
   assign do_push = push && (!full || do_pop);
   // Gating keeps the outputs at zero after reset and while empty.
   assign head    = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keyctl.sv
// ps2_keyctl -- PS/2 scan-code set 2 prefix decoder with event queue.
//   clock, reset (async, active-low)
//   bus (ps2_keyctl_if.slave): rx byte strobe in, key events out
//   err_clr : clears the sticky flags
//   ovf     : sticky, an event was dropped on a full queue
//   kbd_err : sticky, keyboard sent 00 or FF
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes.
module ps2_keyctl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic              clock,
   input  logic              reset,
   ps2_keyctl_if.slave       bus,
   input  logic              err_clr,
   output logic              ovf,
   output logic              kbd_err
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   dec_state_t     state_reg, state_next;
   logic [CW-1:0]  tmo_cnt_reg, tmo_cnt_next;
   logic           timed_out;
   logic           emit;
   logic           set_kbd_err;
   ps2_evt_t       evt;
   logic           suppress;
   logic           push;
   logic           fifo_full, fifo_empty, fifo_drop;
   ps2_evt_t       head;
   logic           ovf_reg, kbd_err_reg;

   // ---------------- state register ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         tmo_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         tmo_cnt_reg <= tmo_cnt_next;
      end
   end

   // Counts idle cycles spent waiting for the byte after a prefix.
   assign timed_out = (state_reg != IDLE) && !bus.rx_valid &&
                      (tmo_cnt_reg == CW'(TIMEOUT_CYC - 1));

   always_comb begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
      if (state_reg == IDLE || bus.rx_valid || timed_out) tmo_cnt_next = '0;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      if (bus.rx_valid) begin
         if (is_bad(bus.rx_data)) begin
            state_next = IDLE;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (bus.rx_data == BYTE_E0)      state_next = GOT_E0;
                  else if (bus.rx_data == BYTE_F0) state_next = GOT_F0;
               end
               GOT_E0: begin
                  if (bus.rx_data == BYTE_F0)       state_next = GOT_E0F0;
                  else if (bus.rx_data != BYTE_E0)  state_next = IDLE;
               end
               GOT_F0: begin
                  if (bus.rx_data == BYTE_E0)       state_next = GOT_E0F0;
                  else if (bus.rx_data != BYTE_F0)  state_next = IDLE;
               end
               GOT_E0F0: begin
                  if (!is_prefix(bus.rx_data))      state_next = IDLE;
               end
               default: state_next = IDLE;
            endcase
         end
      end else if (timed_out) begin
         state_next = IDLE;
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      emit        = 1'b0;
      set_kbd_err = 1'b0;
      evt.code    = bus.rx_data;
      evt.ext     = (state_reg == GOT_E0) || (state_reg == GOT_E0F0);
      evt.brk     = (state_reg == GOT_F0) || (state_reg == GOT_E0F0);
      if (bus.rx_valid) begin
         if (is_bad(bus.rx_data))
            set_kbd_err = 1'b1;
         else if (!is_prefix(bus.rx_data) &&
                  !(state_reg == IDLE && is_ctrl(bus.rx_data)))
            emit = 1'b1;
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   // Last make seen; a repeat of it is typematic and gets suppressed.
   logic       last_valid_reg;
   logic [7:0] last_code_reg;
   logic       last_ext_reg;
   logic       key_match;

   assign key_match = last_valid_reg && (last_code_reg == evt.code) &&
                      (last_ext_reg == evt.ext);
   assign suppress  = !evt.brk && key_match;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_valid_reg <= 1'b0;
         last_code_reg  <= '0;
         last_ext_reg   <= 1'b0;
      end else if (emit) begin
         if (!evt.brk) begin
            last_valid_reg <= 1'b1;
            last_code_reg  <= evt.code;
            last_ext_reg   <= evt.ext;
         end else if (key_match) begin
            last_valid_reg <= 1'b0;
         end
      end
   end
`else
   assign suppress = 1'b0;
`endif

   assign push = emit && !suppress;

   ps2_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (evt),
      .pop       (bus.ev_ready),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Full queue only accepts a push when the head leaves in the same edge.
   assign fifo_drop = push && fifo_full && !bus.ev_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ovf_reg     <= 1'b0;
         kbd_err_reg <= 1'b0;
      end else begin
         if (fifo_drop)        ovf_reg <= 1'b1;
         else if (err_clr)     ovf_reg <= 1'b0;
         if (set_kbd_err)      kbd_err_reg <= 1'b1;
         else if (err_clr)     kbd_err_reg <= 1'b0;
      end
   end

   assign ovf          = ovf_reg;
   assign kbd_err      = kbd_err_reg;
   assign bus.ev_valid = !fifo_empty;
   assign bus.ev_code  = head.code;
   assign bus.ev_ext   = head.ext;
   assign bus.ev_break = head.brk;

endmodule

// File: tb/tb_ps2_keyctl.sv
// tb_ps2_keyctl -- scoreboard bench for ps2_keyctl (FIFO_DEPTH=4,
// TIMEOUT_CYC=20). Stimulus pushes expected events into exp_q; the monitor
// pops and compares every event the DUT hands over.
module tb_ps2_keyctl;

   localparam int DEPTH = 4;
   localparam int TMO   = 20;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic err_clr = 1'b0;
   logic ovf, kbd_err;

   ps2_keyctl_if bus ();

   ps2_keyctl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus),
      .err_clr (err_clr),
      .ovf     (ovf),
      .kbd_err (kbd_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   logic [9:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
      exp_q.push_back({code, ext, brk});
   endtask

   // Called at posedge+1; presents one byte for exactly one cycle.
   task automatic send(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clock); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clock); #1;
         n++;
      end
      idle(3);
      chk(name, exp_q.size(), 0);
   endtask

   // Monitor: compares each accepted head event against the scoreboard.
   always @(negedge clock) begin
      if (reset && bus.ev_valid && bus.ev_ready) begin
         logic [9:0] got;
         got = {bus.ev_code, bus.ev_ext, bus.ev_break};
         $display("EVT code=%02h ext=%0d brk=%0d", bus.ev_code, bus.ev_ext, bus.ev_break);
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got 0x%0h required none", got);
         end else begin
            logic [9:0] req;
            req = exp_q.pop_front();
            if (got !== req) begin
               failures++;
               $display("FAIL event: got 0x%0h required 0x%0h", got, req);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.ev_ready = 1'b1;
      idle(3);
      // Reset state
      chk("rst_ev_valid", bus.ev_valid, 0);
      chk("rst_ev_code", bus.ev_code, 0);
      chk("rst_ev_ext", bus.ev_ext, 0);
      chk("rst_ev_break", bus.ev_break, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_kbd_err", kbd_err, 0);
      reset = 1'b1;
      idle(2);

      // Single make, latency 1
      expect_evt(8'h1C, 0, 0);
      chk("pre_valid", bus.ev_valid, 0);
      send(8'h1C);
      chk("latency1_valid", bus.ev_valid, 1);
      drain("make_1c");

      // Extended break, extended make, repeated prefixes
      expect_evt(8'h75, 1, 1);
      send(8'hE0); send(8'hF0); send(8'h75);
      expect_evt(8'h14, 1, 0);
      send(8'hE0); send(8'hE0); send(8'h14);
      expect_evt(8'h14, 0, 1);
      send(8'hF0); send(8'hF0); send(8'h14);
      expect_evt(8'h4A, 1, 1);
      send(8'hF0); send(8'hE0); send(8'h4A);
      drain("prefix_seq");

      // Overflow: five makes into a 4-deep queue with no consumer
      bus.ev_ready = 1'b0;
      expect_evt(8'h15, 0, 0); expect_evt(8'h1D, 0, 0);
      expect_evt(8'h24, 0, 0); expect_evt(8'h2D, 0, 0);
      send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
      chk("ovf_before_drop", ovf, 0);
      send(8'h2C);
      chk("ovf_set", ovf, 1);
      chk("head_stable", bus.ev_code, 8'h15);
      bus.ev_ready = 1'b1;
      drain("ovf_drain");
      chk("ovf_sticky", ovf, 1);
      err_clr = 1'b1; idle(1); err_clr = 1'b0;
      chk("ovf_cleared", ovf, 0);

      // Push while full with same-cycle pop is accepted
      bus.ev_ready = 1'b0;
      expect_evt(8'h16, 0, 0); expect_evt(8'h1E, 0, 0);
      expect_evt(8'h26, 0, 0); expect_evt(8'h25, 0, 0);
      expect_evt(8'h2E, 0, 0);
      send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
      bus.ev_ready = 1'b1;
      send(8'h2E);
      chk("full_pop_no_ovf", ovf, 0);
      drain("full_pop_drain");

      // Prefix timeout boundary: one cycle short keeps the break
      expect_evt(8'h1C, 0, 1);
      send(8'hF0); idle(TMO - 1); send(8'h1C);
      expect_evt(8'h1C, 0, 0);
      send(8'hF0); idle(TMO); send(8'h1C);
      drain("timeout");

      // Control bytes dropped, error bytes flagged
      send(8'hAA); send(8'hFA); send(8'hFE); send(8'hEE); send(8'hFF);
      drain("ctrl_no_events");
      chk("kbd_err_set", kbd_err, 1);
      err_clr = 1'b1; idle(1); err_clr = 1'b0;
      chk("kbd_err_clr", kbd_err, 0);
      err_clr = 1'b1; send(8'h00); err_clr = 1'b0;
      chk("kbd_err_set_wins", kbd_err, 1);
      send(8'hE0); send(8'hFF);   // error inside prefix returns to IDLE
      expect_evt(8'h1C, 0, 0);
      send(8'h1C);
      drain("err_in_prefix");

      // Reset mid-sequence with a queued event and a pending prefix
      bus.ev_ready = 1'b0;
      send(8'h2D); send(8'hE0); send(8'hF0);
      reset = 1'b0;
      idle(2);
      chk("midrst_valid", bus.ev_valid, 0);
      chk("midrst_kbd_err", kbd_err, 0);
      reset = 1'b1;
      idle(1);
      bus.ev_ready = 1'b1;
      expect_evt(8'h1C, 0, 0);
      send(8'h1C);
      drain("after_reset");

      // Typematic repeat
      expect_evt(8'h1C, 0, 0);
`ifndef PS2_TYPEMATIC_FILTER_EN
      expect_evt(8'h1C, 0, 0);
      expect_evt(8'h1C, 0, 0);
`endif
      expect_evt(8'h1C, 0, 1);
      expect_evt(8'h1C, 0, 0);
      send(8'h1C); send(8'h1C); send(8'h1C);
      send(8'hF0); send(8'h1C);
      send(8'h1C);
      drain("typematic");

      chk("end_idle", bus.ev_valid, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_keyctl.md
PS2_KEYCTL -- requirements
Module: ps2_keyctl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event queue depth; power of two, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, clocks allowed after a prefix byte before the prefix is abandoned.
REQ-003 SHALL have port clock, input, 1, single system clock, rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port rx_valid, input, 1, one-cycle strobe from the PS/2 receiver marking a received byte.
REQ-006 SHALL have port rx_data, input, 8, received byte; valid only when rx_valid=1.
REQ-007 SHALL have port ev_valid, output, 1, event available at queue head.
REQ-008 SHALL have port ev_ready, input, 1, consumer accepts head event when ev_valid=1.
REQ-009 SHALL have port ev_code, output, 8, scan code of head event.
REQ-010 SHALL have port ev_ext, output, 1, head event carried the E0 prefix.
REQ-011 SHALL have port ev_break, output, 1, head event is a key release (F0 prefix).
REQ-012 SHALL have port err_clr, input, 1, clears the sticky flags.
REQ-013 SHALL have port ovf, output, 1, sticky flag: event dropped because the queue was full.
REQ-014 SHALL have port kbd_err, output, 1, sticky flag: keyboard sent 8'h00 or 8'hFF.

Function
REQ-015 SHALL decode with states IDLE, GOT_E0, GOT_F0, GOT_E0F0; each transition advances only on a cycle with rx_valid=1.
REQ-016 IDLE: E0->GOT_E0; F0->GOT_F0; AA/FA/FE/EE dropped, stay; 00/FF set kbd_err, stay; any other byte emits make {code, ext=0}.
REQ-017 GOT_E0: F0->GOT_E0F0; E0 stays; a non-prefix byte emits make {code, ext=1} and returns to IDLE.
REQ-018 GOT_F0: E0->GOT_E0F0; F0 stays; a non-prefix byte emits break {code, ext=0} and returns to IDLE.
REQ-019 GOT_E0F0: E0/F0 stay; a non-prefix byte emits break {code, ext=1} and returns to IDLE.
REQ-020 In any prefix state, 00/FF SHALL set kbd_err and return to IDLE without emitting.
REQ-021 Prefix timeout: TIMEOUT_CYC consecutive cycles in a non-IDLE state without rx_valid SHALL return to IDLE with no emit; the counter restarts on every rx_valid.
REQ-022 An emitted event SHALL be pushed into the queue in the same edge as rx_valid; when the queue was empty, ev_valid=1 on the next cycle (latency 1).
REQ-023 The queue SHALL be show-ahead: ev_code/ev_ext/ev_break are valid whenever ev_valid=1 and stay stable until popped.
REQ-024 Pop occurs on a cycle with ev_valid&ev_ready; no pop when ev_valid=0.
REQ-025 Push while full without a same-cycle pop SHALL drop the event and set ovf; push with a same-cycle pop while full SHALL be accepted.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-027 err_clr SHALL clear ovf and kbd_err; a same-cycle set event SHALL win over the clear.

Reset
REQ-028 Asserting reset SHALL force state IDLE, queue empty, timeout counter 0, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ovf=0, kbd_err=0.
REQ-029 Reset mid-sequence (prefix state or non-empty queue) SHALL discard all partial and queued data; the first byte after release is decoded from IDLE.

Configuration
REQ-030 Macro PS2_TYPEMATIC_FILTER_EN defined: a make identical to the last accepted make {code, ext} SHALL be suppressed; the stored key is cleared by its break, replaced by any other make, and cleared by reset.
REQ-031 Macro undefined: every make SHALL be emitted, including auto-repeat makes, and no filter storage is synthesized.

Structure
REQ-032 Package ps2_pkg SHALL hold byte constants E0, F0, AA, FA, FE, EE, 00, FF; the decoder state enum; and the event record {code[7:0], ext, brk}.
REQ-033 The queue SHALL be a sub-module ps2_evt_fifo (parameter FIFO_DEPTH, push/pop/full/empty, record-wide data); the decoder FSM and timeout stay in ps2_keyctl.

Verification
REQ-034 Bytes 1C with ev_ready=1 -> one event {1C, ext=0, brk=0}; ev_valid high one cycle after rx_valid.
REQ-035 Bytes E0,F0,75 -> single event {75, ext=1, brk=1}; prefixes produce no events.
REQ-036 ev_ready=0, five makes 15,1D,24,2D,2C with FIFO_DEPTH=4 -> the first four are queued in order, ovf=1; err_clr -> ovf=0.
REQ-037 Byte F0, then no input for TIMEOUT_CYC cycles, then 1C -> make {1C, 0, 0}, not a break.
REQ-038 Bytes AA, FA, FF -> no events, kbd_err=1; reset pulse inside E0,F0 then byte 1C -> make {1C, 0, 0} only.
REQ-039 With PS2_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C,1C -> events make 1C, break 1C, make 1C; without the macro -> five events.
